ffdiv_issuer: RTL and testbench

- Hardware initiator for the 32-bit floating-point divider (ffdiv_top).
- Accepts operand pairs on a valid/ready request stream and drives en/operand1/operand2 to the divider.
- Captures result, flag and itr_count on the divider's ready pulse and returns them on a valid/ready response stream with a measured cycle latency.
- Sits between a command source (CPU/DMA shim) and ffdiv_top; replaces the bench-only drive/sample sequence in hardware.

---
 rtl/ffdiv_pkg.sv | 27 ++
 rtl/ffdiv_lat_stats.sv | 49 ++++
 rtl/ffdiv_issuer.sv | 182 ++++++++++++++++++
 tb/tb_ffdiv_issuer.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ffdiv_pkg.sv
// ffdiv_pkg: types and constants shared by the ffdiv issuer and its helpers.
// Default widths match the ffdiv_top divider: 32-bit operands, 5-bit flags.
package ffdiv_pkg;

    localparam int FFDIV_OPW = 32;
    localparam int FFDIV_FLW = 5;

    // Width of the latency statistics accumulators.
    localparam int STAT_W = 32;

    // Quiet NaN returned when the divider never answers.
    localparam logic [31:0] QNAN_32 = 32'h7FC0_0000;

    // Bit positions inside the divider flag vector.
    localparam int NANF = 4;
    localparam int OVF  = 3;
    localparam int INF  = 2;
    localparam int UF   = 1;
    localparam int ZF   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } issuer_state_t;

endpackage

// File: rtl/ffdiv_lat_stats.sv
// ffdiv_lat_stats: running sum of divide latencies and count of completed
// divides. A clear request wins over an increment in the same cycle.
module ffdiv_lat_stats
    import ffdiv_pkg::*;
#(
    parameter int LATW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [LATW-1:0]   lat_i,
    output logic [STAT_W-1:0] sum_o,
    output logic [STAT_W-1:0] run_o
);

    logic [STAT_W-1:0] sum_q, sum_d;
    logic [STAT_W-1:0] run_q, run_d;

    // Next counter values: clear, accumulate, or hold.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sum_d = sum_q;
        run_d = run_q;
        if (clr_i) begin
            sum_d = '0;
            run_d = '0;
        end else if (inc_i) begin
            sum_d = sum_q + STAT_W'(lat_i);
            run_d = run_q + STAT_W'(1);
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
            run_q <= '0;
        end else begin
            sum_q <= sum_d;
            run_q <= run_d;
        end
    end

    assign sum_o = sum_q;
    assign run_o = run_q;

endmodule

// File: rtl/ffdiv_issuer.sv
// ffdiv_issuer: accepts one operand pair at a time, drives the ffdiv_top
// divider, captures its answer on div_ready (or a watchdog QNaN after
// TIMEOUT_CYCLES) and holds it on the response stream until consumed.
// Define FFDIV_STATS_EN to add the latency statistics ports and counters.
module ffdiv_issuer
    import ffdiv_pkg::*;
#(
    parameter int OPW            = FFDIV_OPW,
    parameter int FLW            = FFDIV_FLW,
    parameter int ITRW           = $clog2(OPW),
    parameter int LATW           = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OPW-1:0]    req_op1,
    input  logic [OPW-1:0]    req_op2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [OPW-1:0]    rsp_result,
    output logic [FLW-1:0]    rsp_flag,
    output logic [ITRW-1:0]   rsp_itr,
    output logic [LATW-1:0]   rsp_latency,
    output logic              rsp_timeout,
    output logic              div_en,
    output logic [OPW-1:0]    div_operand1,
    output logic [OPW-1:0]    div_operand2,
    input  logic [OPW-1:0]    div_result,
    input  logic [FLW-1:0]    div_flag,
    input  logic [ITRW-1:0]   div_itr_count,
`ifdef FFDIV_STATS_EN
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_count_sum,
    output logic [STAT_W-1:0] stat_count_run,
`endif
    input  logic              div_ready
);

    localparam logic [LATW-1:0] TIMEOUT_LAT    = LATW'(TIMEOUT_CYCLES);
    localparam logic [OPW-1:0]  TIMEOUT_RESULT = OPW'(QNAN_32);
    localparam logic [FLW-1:0]  TIMEOUT_FLAG   = FLW'(1 << NANF);

    issuer_state_t   state_q, state_d;
    logic [OPW-1:0]  op1_q, op1_d;
    logic [OPW-1:0]  op2_q, op2_d;
    logic [LATW-1:0] lat_cnt_q, lat_cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [OPW-1:0]  rsp_result_q, rsp_result_d;
    logic [FLW-1:0]  rsp_flag_q, rsp_flag_d;
    logic [ITRW-1:0] rsp_itr_q, rsp_itr_d;
    logic [LATW-1:0] rsp_latency_q, rsp_latency_d;
    logic            rsp_timeout_q, rsp_timeout_d;

    logic accept;   // request handshake completes this cycle
    logic capture;  // divider answered during BUSY
    logic expire;   // watchdog fires during BUSY (divider silent)

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state is written with <= so every register samples
        // pre-edge values regardless of block or statement order.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: issue, wait for answer or watchdog, wait for ready low.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)             state_d = BUSY;
            BUSY:    if (capture || expire)  state_d = DRAIN;
            DRAIN:   if (!div_ready)         state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // State-decoded outputs and strobes; a lingering div_ready blocks issue.
    always_comb begin
        req_ready = (state_q == IDLE) && !rsp_valid_q && !div_ready;
        div_en    = (state_q == BUSY);
        accept    = req_valid && req_ready;
        capture   = (state_q == BUSY) && div_ready;
        expire    = (state_q == BUSY) && !div_ready && (lat_cnt_q == TIMEOUT_LAT);
    end

    // Datapath next values: operand latch, latency count, response capture.
    always_comb begin
        op1_d         = op1_q;
        op2_d         = op2_q;
        lat_cnt_d     = lat_cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_flag_d    = rsp_flag_q;
        rsp_itr_d     = rsp_itr_q;
        rsp_latency_d = rsp_latency_q;
        rsp_timeout_d = rsp_timeout_q;

        if (accept) begin
            op1_d     = req_op1;
            op2_d     = req_op2;
            lat_cnt_d = LATW'(1);
        end else if (div_en && !capture && !expire) begin
            lat_cnt_d = (lat_cnt_q == '1) ? lat_cnt_q : lat_cnt_q + LATW'(1);
        end

        // A new response can only appear in BUSY, which is never entered
        // while one is still held, so capture and consume never collide.
        if (capture) begin
            rsp_valid_d   = 1'b1;
            rsp_result_d  = div_result;
            rsp_flag_d    = div_flag;
            rsp_itr_d     = div_itr_count;
            rsp_latency_d = lat_cnt_q;
            rsp_timeout_d = 1'b0;
        end else if (expire) begin
            rsp_valid_d   = 1'b1;
            rsp_result_d  = TIMEOUT_RESULT;
            rsp_flag_d    = TIMEOUT_FLAG;
            rsp_itr_d     = '0;
            rsp_latency_d = TIMEOUT_LAT;
            rsp_timeout_d = 1'b1;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d   = 1'b0;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op1_q         <= '0;
            op2_q         <= '0;
            lat_cnt_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_flag_q    <= '0;
            rsp_itr_q     <= '0;
            rsp_latency_q <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            op1_q         <= op1_d;
            op2_q         <= op2_d;
            lat_cnt_q     <= lat_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_flag_q    <= rsp_flag_d;
            rsp_itr_q     <= rsp_itr_d;
            rsp_latency_q <= rsp_latency_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign div_operand1 = op1_q;
    assign div_operand2 = op2_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_flag     = rsp_flag_q;
    assign rsp_itr      = rsp_itr_q;
    assign rsp_latency  = rsp_latency_q;
    assign rsp_timeout  = rsp_timeout_q;

`ifdef FFDIV_STATS_EN
    // Latency of each real divider answer feeds the statistics; watchdog
    // responses are not counted.
    ffdiv_lat_stats #(
        .LATW (LATW)
    ) u_stats (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (stat_clr),
        .inc_i (capture),
        .lat_i (lat_cnt_q),
        .sum_o (stat_count_sum),
        .run_o (stat_count_run)
    );
`endif

endmodule

// File: tb/tb_ffdiv_issuer.sv
// tb_ffdiv_issuer: self-checking bench for ffdiv_issuer with a behavioural
// divider that answers on a programmable en-high cycle (0 = never).
module tb_ffdiv_issuer;
    import ffdiv_pkg::*;

    localparam int OPW  = 32;
    localparam int FLW  = 5;
    localparam int ITRW = 5;
    localparam int LATW = 8;
    localparam int TO   = 64;

    typedef struct packed {
        logic [OPW-1:0]  result;
        logic [FLW-1:0]  flag;
        logic [ITRW-1:0] itr;
        logic [LATW-1:0] lat;
        logic            timeout;
    } rsp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [OPW-1:0]  req_op1 = '0;
    logic [OPW-1:0]  req_op2 = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [OPW-1:0]  rsp_result;
    logic [FLW-1:0]  rsp_flag;
    logic [ITRW-1:0] rsp_itr;
    logic [LATW-1:0] rsp_latency;
    logic            rsp_timeout;
    logic            div_en;
    logic [OPW-1:0]  div_operand1;
    logic [OPW-1:0]  div_operand2;
    logic [OPW-1:0]  div_result = 32'hDEAD_BEEF;
    logic [FLW-1:0]  div_flag = '1;
    logic [ITRW-1:0] div_itr_count = '1;
    logic            div_ready;
`ifdef FFDIV_STATS_EN
    logic            stat_clr = 1'b0;
    logic [31:0]     stat_count_sum;
    logic [31:0]     stat_count_run;
`endif

    // Divider model controls (written by tests) and state (written by model).
    int              mdl_lat = 0;
    logic [OPW-1:0]  mdl_result = '0;
    logic [FLW-1:0]  mdl_flag = '0;
    logic [ITRW-1:0] mdl_itr = '0;
    logic            mdl_ready = 1'b0;
    logic            stale_ready = 1'b0;
    int              en_cnt = 0;

    int   n_checks = 0;
    int   n_fail = 0;
    rsp_t exp_q[$];

    assign div_ready = mdl_ready | stale_ready;

    always #5 clk = ~clk;

    ffdiv_issuer #(
        .OPW(OPW), .FLW(FLW), .ITRW(ITRW), .LATW(LATW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flag(rsp_flag), .rsp_itr(rsp_itr),
        .rsp_latency(rsp_latency), .rsp_timeout(rsp_timeout),
        .div_en(div_en), .div_operand1(div_operand1), .div_operand2(div_operand2),
        .div_result(div_result), .div_flag(div_flag), .div_itr_count(div_itr_count),
`ifdef FFDIV_STATS_EN
        .stat_clr(stat_clr), .stat_count_sum(stat_count_sum), .stat_count_run(stat_count_run),
`endif
        .div_ready(div_ready)
    );

    // Behavioural divider: counts en-high cycles, raises ready with the
    // programmed answer on cycle mdl_lat, drops it once en goes low.
    always @(negedge clk) begin
        if (div_en) begin
            en_cnt = en_cnt + 1;
            if (en_cnt == mdl_lat) begin
                mdl_ready     = 1'b1;
                div_result    = mdl_result;
                div_flag      = mdl_flag;
                div_itr_count = mdl_itr;
            end
        end else begin
            en_cnt        = 0;
            mdl_ready     = 1'b0;
            div_result    = 32'hDEAD_BEEF;
            div_flag      = '1;
            div_itr_count = '1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic rsp_t mk(input logic [OPW-1:0] r, input logic [FLW-1:0] f,
                                input logic [ITRW-1:0] i, input logic [LATW-1:0] l,
                                input logic t);
        rsp_t x;
        x.result = r; x.flag = f; x.itr = i; x.lat = l; x.timeout = t;
        return x;
    endfunction

    function automatic rsp_t obs();
        return {rsp_result, rsp_flag, rsp_itr, rsp_latency, rsp_timeout};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_req(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                            input int budget, output bit ok);
        ok = 1'b0;
        req_op1 = a;
        req_op2 = b;
        req_valid = 1'b1;
        #1;
        for (int i = 0; i < budget && !ok; i++) begin
            if (req_ready) ok = 1'b1;
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output int cycles, output bit ok);
        cycles = 0;
        while (!rsp_valid && cycles < budget) begin
            tick();
            cycles++;
        end
        ok = rsp_valid;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    // Issue one op and collect its response (consumed immediately).
    task automatic run_op(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                          input int req_budget, output bit acc, output bit got_rsp,
                          output int cycles, output rsp_t got);
        send_req(a, b, req_budget, acc);
        wait_rsp(200, cycles, got_rsp);
        got = obs();
        if (got_rsp) consume();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({rsp_valid, div_en, div_operand1, div_operand2} !== '0 || obs() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b en=%b op1=%h op2=%h rsp=%h, required all zero",
                     rsp_valid, div_en, div_operand1, div_operand2, obs());
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_req_ready: got %b, required 1", req_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bit acc, got_rsp; int cyc; rsp_t exp;
        mdl_lat = 7; mdl_result = 32'h4040_0000; mdl_flag = '0; mdl_itr = 5'd23;
        exp_q.push_back(mk(32'h4040_0000, '0, 5'd23, 8'd7, 1'b0));
        send_req(32'h40C0_0000, 32'h4000_0000, 4, acc);
        n_checks++;
        if (!acc || div_en !== 1'b1 || div_operand1 !== 32'h40C0_0000 || div_operand2 !== 32'h4000_0000) begin
            n_fail++;
            $display("FAIL basic_issue: acc=%b en=%b op1=%h op2=%h, required 1 1 40c00000 40000000",
                     acc, div_en, div_operand1, div_operand2);
        end
        wait_rsp(200, cyc, got_rsp);
        exp = exp_q.pop_front();
        n_checks++;
        if (!got_rsp || obs() !== exp || cyc != 7) begin
            n_fail++;
            $display("FAIL basic_rsp: got %h after %0d cycles, required %h after 7", obs(), cyc, exp);
        end
        n_checks++;
        if (div_en !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_en_drop: div_en %b after capture, required 0", div_en);
        end
        consume();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_consume: rsp_valid %b, required 0", rsp_valid);
        end
    endtask

    task automatic test_hold();
        bit acc, got_rsp; int cyc; rsp_t exp;
        mdl_lat = 3; mdl_result = 32'h3F80_0000; mdl_flag = 5'b00001; mdl_itr = 5'd9;
        exp_q.push_back(mk(32'h3F80_0000, 5'b00001, 5'd9, 8'd3, 1'b0));
        send_req(32'h4000_0000, 32'h4000_0000, 4, acc);
        wait_rsp(200, cyc, got_rsp);
        exp = exp_q.pop_front();
        req_op1 = 32'h4110_0000; req_op2 = 32'h4040_0000; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (!got_rsp || rsp_valid !== 1'b1 || obs() !== exp || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: valid=%b rsp=%h req_ready=%b, required 1 %h 0",
                         i, rsp_valid, obs(), req_ready, exp);
            end
            tick();
        end
        mdl_lat = 4; mdl_result = 32'h4040_0000; mdl_flag = '0; mdl_itr = 5'd11;
        exp_q.push_back(mk(32'h4040_0000, '0, 5'd11, 8'd4, 1'b0));
        consume();
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: valid=%b req_ready=%b, required 0 1", rsp_valid, req_ready);
        end
        tick();
        req_valid = 1'b0;
        n_checks++;
        if (div_en !== 1'b1 || div_operand1 !== 32'h4110_0000) begin
            n_fail++;
            $display("FAIL hold_next_issue: en=%b op1=%h, required 1 41100000", div_en, div_operand1);
        end
        wait_rsp(200, cyc, got_rsp);
        exp = exp_q.pop_front();
        n_checks++;
        if (!got_rsp || obs() !== exp) begin
            n_fail++;
            $display("FAIL hold_next_rsp: got %h, required %h", obs(), exp);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        bit acc, got_rsp; int cyc; rsp_t got, exp;
        for (int k = 1; k <= 3; k++) begin
            mdl_lat = k; mdl_result = 32'h4000_0000 + k; mdl_flag = FLW'(k); mdl_itr = ITRW'(k + 2);
            exp_q.push_back(mk(32'h4000_0000 + k, FLW'(k), ITRW'(k + 2), LATW'(k), 1'b0));
            run_op(32'h1000_0000 * k, 32'h3F80_0000, 1, acc, got_rsp, cyc, got);
            exp = exp_q.pop_front();
            n_checks++;
            if (!acc || !got_rsp || got !== exp || cyc != k) begin
                n_fail++;
                $display("FAIL b2b_op%0d: acc=%b got %h after %0d, required %h after %0d",
                         k, acc, got, cyc, exp, k);
            end
        end
    endtask

    task automatic test_timeout();
        bit acc, got_rsp; int cyc; rsp_t got, exp;
        mdl_lat = 0;
        exp_q.push_back(mk(32'h7FC0_0000, 5'b10000, '0, 8'd64, 1'b1));
        run_op(32'h4000_0000, 32'h0000_0000, 4, acc, got_rsp, cyc, got);
        exp = exp_q.pop_front();
        n_checks++;
        if (!acc || !got_rsp || got !== exp || cyc != TO) begin
            n_fail++;
            $display("FAIL timeout_rsp: got %h after %0d, required %h after %0d", got, cyc, exp, TO);
        end
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_recover: valid=%b req_ready=%b, required 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_priority();
        bit acc, got_rsp; int cyc; rsp_t got, exp;
        mdl_lat = TO; mdl_result = 32'h4120_0000; mdl_flag = 5'b01000; mdl_itr = 5'd30;
        exp_q.push_back(mk(32'h4120_0000, 5'b01000, 5'd30, 8'd64, 1'b0));
        run_op(32'h4220_0000, 32'h4000_0000, 4, acc, got_rsp, cyc, got);
        exp = exp_q.pop_front();
        n_checks++;
        if (!acc || !got_rsp || got !== exp || cyc != TO) begin
            n_fail++;
            $display("FAIL ready_beats_timeout: got %h after %0d, required %h after %0d", got, cyc, exp, TO);
        end
    endtask

    task automatic test_mid_reset();
        bit acc, got_rsp; int cyc; rsp_t got, exp;
        mdl_lat = 7; mdl_result = 32'h1111_1111; mdl_flag = 5'b00100; mdl_itr = 5'd1;
        send_req(32'h4080_0000, 32'h4000_0000, 4, acc);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({rsp_valid, div_en, div_operand1, div_operand2} !== '0 || obs() !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: valid=%b en=%b op1=%h op2=%h rsp=%h, required all zero",
                     rsp_valid, div_en, div_operand1, div_operand2, obs());
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (rsp_valid !== 1'b0 || div_en !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_quiet%0d: valid=%b en=%b, required 0 0", i, rsp_valid, div_en);
            end
        end
        mdl_lat = 5; mdl_result = 32'h4000_0000; mdl_flag = '0; mdl_itr = 5'd17;
        exp_q.push_back(mk(32'h4000_0000, '0, 5'd17, 8'd5, 1'b0));
        run_op(32'h4080_0000, 32'h4000_0000, 1, acc, got_rsp, cyc, got);
        exp = exp_q.pop_front();
        n_checks++;
        if (!acc || !got_rsp || got !== exp) begin
            n_fail++;
            $display("FAIL midreset_next: acc=%b got %h, required %h", acc, got, exp);
        end
    endtask

    task automatic test_stale_ready();
        bit acc, got_rsp; int cyc; rsp_t got, exp;
        stale_ready = 1'b1;
        req_op1 = 32'h4500_0000; req_op2 = 32'h4100_0000; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (req_ready !== 1'b0 || div_en !== 1'b0 || rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL stale_block%0d: req_ready=%b en=%b valid=%b, required 0 0 0",
                         i, req_ready, div_en, rsp_valid);
            end
        end
        req_valid = 1'b0;
        stale_ready = 1'b0;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stale_release: valid=%b req_ready=%b, required 0 1", rsp_valid, req_ready);
        end
        mdl_lat = 6; mdl_result = 32'h4380_0000; mdl_flag = '0; mdl_itr = 5'd6;
        exp_q.push_back(mk(32'h4380_0000, '0, 5'd6, 8'd6, 1'b0));
        run_op(32'h4500_0000, 32'h4100_0000, 1, acc, got_rsp, cyc, got);
        exp = exp_q.pop_front();
        n_checks++;
        if (!acc || !got_rsp || got !== exp) begin
            n_fail++;
            $display("FAIL stale_next: acc=%b got %h, required %h", acc, got, exp);
        end
    endtask

`ifdef FFDIV_STATS_EN
    task automatic test_stats();
        bit acc, got_rsp; int cyc; rsp_t got, exp;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        for (int k = 5; k <= 9; k++) begin
            mdl_lat = k; mdl_result = 32'h3F00_0000 + k; mdl_flag = '0; mdl_itr = ITRW'(k);
            exp_q.push_back(mk(32'h3F00_0000 + k, '0, ITRW'(k), LATW'(k), 1'b0));
            run_op(32'h4000_0000, 32'h4000_0000 + k, 4, acc, got_rsp, cyc, got);
            exp = exp_q.pop_front();
            n_checks++;
            if (!got_rsp || got !== exp) begin
                n_fail++;
                $display("FAIL stats_op%0d: got %h, required %h", k, got, exp);
            end
        end
        mdl_lat = 0;
        exp_q.push_back(mk(32'h7FC0_0000, 5'b10000, '0, 8'd64, 1'b1));
        run_op(32'h4000_0000, 32'h0, 4, acc, got_rsp, cyc, got);
        exp = exp_q.pop_front();
        n_checks++;
        if (!got_rsp || got !== exp) begin
            n_fail++;
            $display("FAIL stats_timeout: got %h, required %h", got, exp);
        end
        n_checks++;
        if (stat_count_sum !== 32'd35 || stat_count_run !== 32'd5) begin
            n_fail++;
            $display("FAIL stats_totals: sum=%0d run=%0d, required 35 5", stat_count_sum, stat_count_run);
        end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        n_checks++;
        if (stat_count_sum !== 32'd0 || stat_count_run !== 32'd0) begin
            n_fail++;
            $display("FAIL stats_clear: sum=%0d run=%0d, required 0 0", stat_count_sum, stat_count_run);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_timeout();
        test_priority();
        test_mid_reset();
        test_stale_ready();
`ifdef FFDIV_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
